// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes, FSM states and
// default geometry of the byte-addressed memory.
package dmem_lsu_pkg;

    localparam int unsigned AW_DEFAULT    = 10;
    localparam int unsigned DEPTH_DEFAULT = 1024;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapt,
        StWrite,
        StResp
    } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response handshake plus data-memory port of the load/store unit.
// master = the LSU itself, slave = the core and memory around it.
interface dmem_lsu_if
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_rW;
    logic          mem_en;
    logic [31:0]   mem_dataIn;
    logic [31:0]   mem_dataOut;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataOut,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_rW, mem_en, mem_dataIn
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_dataOut,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_rW, mem_en, mem_dataIn
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// Sub-word lane handling: extracts and extends load data from a memory word and
// merges store data into a word for read-modify-write.
module lsu_byte_lane
    import dmem_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        unique case (lane)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];

        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            F3_W:    load_data = word;
            default: load_data = '0;
        endcase

        store_word = wdata;
        case (funct3)
            F3_B: begin
                store_word = word;
                unique case (lane)
                    2'd0: store_word[7:0]   = wdata[7:0];
                    2'd1: store_word[15:8]  = wdata[7:0];
                    2'd2: store_word[23:16] = wdata[7:0];
                    2'd3: store_word[31:24] = wdata[7:0];
                    default: store_word = word;
                endcase
            end
            F3_H: store_word = lane[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
            default: store_word = wdata;
        endcase
    end
endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide, byte-addressed data memory for an RV32I core.
// One request at a time; sub-word stores are done as read-modify-write.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    dmem_lsu_if.master bus
);
    lsu_state_e    state_q, state_d;
    logic [AW-1:0] base_q, base_next;
    logic [1:0]    lane_q;
    logic [2:0]    f3_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic          req_err;

    logic          req_ready_q, resp_valid_q, resp_err_q, mem_en_q, mem_rw_q;
    logic [31:0]   resp_rdata_q, mem_data_in_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   load_data, store_word;

    lsu_byte_lane u_lane (
        .word       (bus.mem_dataOut),
        .lane       (lane_q),
        .funct3     (f3_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // DEPTH is 2**AW, so both range tests agree; either alone rejects out-of-memory addresses.
    always_comb begin
        req_err = (bus.req_addr[31:AW] != '0) || (bus.req_addr >= 32'(DEPTH));
        case (bus.req_funct3)
            F3_B:    ;
            F3_H:    if (bus.req_addr[0]) req_err = 1'b1;
            F3_W:    if (bus.req_addr[1:0] != 2'b00) req_err = 1'b1;
            F3_BU:   if (bus.req_we) req_err = 1'b1;
            F3_HU:   if (bus.req_we || bus.req_addr[0]) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (req_err)                                  state_d = StResp;
                    else if (bus.req_we && bus.req_funct3 == F3_W) state_d = StWrite;
                    else                                          state_d = StRead;
                end
            end
            StRead:  state_d = StCapt;
            StCapt:  state_d = we_q ? StWrite : StResp;
            StWrite: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign base_next = (state_q == StIdle) ? {bus.req_addr[AW-1:2], 2'b00} : base_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            base_q        <= '0;
            lane_q        <= '0;
            f3_q          <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            mem_en_q      <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= (state_d == StIdle);
            resp_valid_q <= (state_d == StResp);
            mem_en_q     <= (state_d == StRead) || (state_d == StWrite);
            mem_rw_q     <= (state_d == StWrite);
            if (state_q == StIdle && bus.req_valid) begin
                base_q  <= base_next;
                lane_q  <= bus.req_addr[1:0];
                f3_q    <= bus.req_funct3;
                we_q    <= bus.req_we;
                wdata_q <= bus.req_wdata;
            end
            if (state_d == StRead || state_d == StWrite) mem_addr_q <= base_next;
            if (state_q == StIdle && state_d == StWrite) mem_data_in_q <= bus.req_wdata;
            if (state_q == StCapt && state_d == StWrite) mem_data_in_q <= store_word;
            if (state_d == StResp) begin
                resp_err_q   <= (state_q == StIdle);
                resp_rdata_q <= (state_q == StCapt && !we_q) ? load_data : '0;
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_rW     = mem_rw_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_dataIn = mem_data_in_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: word memory with a registered read port, a transaction-level
// reference model checked every cycle, and directed requests with literal results.
module tb_dmem_lsu;
    import dmem_lsu_pkg::*;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WORDS = DEPTH / 4;

    typedef struct {
        logic [31:0]   rdata;
        logic          err;
        int            lat;
        int            reads;
        int            writes;
        logic [AW-1:0] base;
        logic [31:0]   wdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dmem_lsu_if #(.AW(AW)) bus ();

    dmem_lsu #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_words [WORDS];
    logic [31:0] ref_mem   [WORDS];
    exp_t        exp_q [$];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_rW) mem_words[bus.mem_addr[AW-1:2]] <= bus.mem_dataIn;
            else            bus.mem_dataOut <= mem_words[bus.mem_addr[AW-1:2]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: what a request must produce, from the ISA-level rules on the reference memory.
    function automatic exp_t predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wd, input bit commit);
        exp_t        e;
        int          size, sh, idx;
        bit          legal;
        logic [31:0] w, v, mask;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        idx   = int'(addr[AW-1:2]);
        sh    = int'(addr[1:0]) * 8;
        w     = ref_mem[idx];
        e.base = AW'(idx * 4);
        e.rdata = '0; e.err = 1'b0; e.reads = 0; e.writes = 0; e.wdata = '0; e.lat = 0;
        if (addr >= 32'(DEPTH) || !legal || (addr % size) != 0) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!we) begin
            e.lat = 3; e.reads = 1;
            v = w >> sh;
            if (size == 1) begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            e.rdata = v;
        end else begin
            e.writes = 1;
            if (size == 4) begin
                e.lat = 2; e.wdata = wd;
            end else begin
                e.lat = 4; e.reads = 1;
                mask = ((size == 1) ? 32'hFF : 32'hFFFF) << sh;
                e.wdata = (w & ~mask) | ((wd << sh) & mask);
            end
            if (commit) ref_mem[idx] = e.wdata;
        end
        return e;
    endfunction

    // Per-cycle compare against the model, sampled on the falling edge.
    logic in_txn = 1'b0;
    int   cyc = 0, acc = 0, k = 0, nrd = 0, nwr = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst) begin
            in_txn = 1'b0;
        end else begin
            cyc++;
            if (in_txn) begin
                k = cyc - acc;
                check("busy_req_ready", 32'(bus.req_ready), 32'd0);
                if (bus.mem_en) begin
                    if (bus.mem_rW) begin
                        nwr++;
                        check("wr_cycle", k, cur.lat - 1);
                        check("wr_addr", 32'(bus.mem_addr), 32'(cur.base));
                        check("wr_data", bus.mem_dataIn, cur.wdata);
                    end else begin
                        nrd++;
                        check("rd_cycle", k, 32'd1);
                        check("rd_addr", 32'(bus.mem_addr), 32'(cur.base));
                    end
                end
                if (k >= cur.lat) begin
                    check("resp_valid_at_lat", 32'(bus.resp_valid), 32'd1);
                    check("model_rdata", bus.resp_rdata, cur.rdata);
                    check("model_err", 32'(bus.resp_err), 32'(cur.err));
                    check("mem_reads", nrd, cur.reads);
                    check("mem_writes", nwr, cur.writes);
                    in_txn = 1'b0;
                end else begin
                    check("resp_early", 32'(bus.resp_valid), 32'd0);
                end
            end else begin
                check("idle_mem_en", 32'(bus.mem_en), 32'd0);
                check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
                check("idle_req_ready", 32'(bus.req_ready), 32'd1);
                if (bus.req_valid && bus.req_ready) begin
                    if (exp_q.size() == 0) begin
                        check("exp_queue", exp_q.size(), 32'd1);
                    end else begin
                        cur = exp_q.pop_front();
                        in_txn = 1'b1;
                        acc = cyc; nrd = 0; nwr = 0;
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the response cycle.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] lit_rdata, input logic lit_err,
                          input bit keep);
        int n;
        exp_q.push_back(predict(we, f3, addr, wd, 1'b1));
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr;  bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        check("accept_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        if (!keep) begin
            bus.req_valid = 1'b0; bus.req_we = ~we; bus.req_funct3 = 3'b111;
            bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = ~wd;
        end
        n = 0;
        while (!bus.resp_valid && n < 10) begin @(posedge clk); #1; n++; end
        check("resp_seen", 32'(bus.resp_valid), 32'd1);
        check("lit_rdata", bus.resp_rdata, lit_rdata);
        check("lit_err", 32'(bus.resp_err), 32'(lit_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        check({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
        check({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
        check({tag, "_mem_rW"}, 32'(bus.mem_rW), 32'd0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_mem_dataIn"}, bus.mem_dataIn, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = '0;    bus.req_wdata = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            mem_words[i] <= 32'h0101_0101 * i + 32'h5A00_0000;
            ref_mem[i]    = 32'h0101_0101 * i + 32'h5A00_0000;
        end
        mem_words[4] <= 32'h8040_20F1;
        ref_mem[4]    = 32'h8040_20F1;
        #1 rst = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Loads of every width and lane from the preloaded word
        do_req(1'b0, F3_B,  32'h10,  32'h0, 32'hFFFF_FFF1, 1'b0, 1'b0);
        do_req(1'b0, F3_BU, 32'h13,  32'h0, 32'h0000_0080, 1'b0, 1'b0);
        do_req(1'b0, F3_H,  32'h12,  32'h0, 32'hFFFF_8040, 1'b0, 1'b0);
        do_req(1'b0, F3_HU, 32'h12,  32'h0, 32'h0000_8040, 1'b0, 1'b0);
        do_req(1'b0, F3_W,  32'h10,  32'h0, 32'h8040_20F1, 1'b0, 1'b0);

        // Sub-word stores (read-modify-write) and a full-word store at the top word
        do_req(1'b1, F3_B,  32'h11,  32'h1234_56AB, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, F3_W,  32'h10,  32'h0, 32'h8040_ABF1, 1'b0, 1'b0);
        do_req(1'b1, F3_H,  32'h12,  32'h0000_BEEF, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, F3_W,  32'h10,  32'h0, 32'hBEEF_ABF1, 1'b0, 1'b0);
        do_req(1'b1, F3_W,  32'h3FC, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, F3_W,  32'h3FC, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        do_req(1'b0, F3_B,  32'h3FF, 32'h0, 32'hFFFF_FFDE, 1'b0, 1'b0);

        // Rejected requests
        do_req(1'b0, F3_W,  32'h12,  32'h0, 32'h0, 1'b1, 1'b0);
        do_req(1'b0, F3_H,  32'h13,  32'h0, 32'h0, 1'b1, 1'b0);
        do_req(1'b0, F3_W,  32'h400, 32'h0, 32'h0, 1'b1, 1'b0);
        do_req(1'b1, F3_BU, 32'h10,  32'h0, 32'h0, 1'b1, 1'b0);

        // Reset during the capture cycle of an SB
        exp_q.push_back(predict(1'b1, F3_B, 32'h10, 32'h0000_0077, 1'b0));
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_B;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h0000_0077;
        for (int n = 0; n < 20 && !bus.req_ready; n++) begin @(posedge clk); #1; end
        check("abort_accept_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("abort_read_en", 32'(bus.mem_en), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, F3_W,  32'h10,  32'h0, 32'hBEEF_ABF1, 1'b0, 1'b0);

        // Back-to-back loads with req_valid held high
        do_req(1'b0, F3_W,  32'h10,  32'h0, 32'hBEEF_ABF1, 1'b0, 1'b1);
        do_req(1'b0, F3_W,  32'h3FC, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        do_req(1'b0, F3_HU, 32'h3FC, 32'h0, 32'h0000_BEEF, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        check("txn_closed", 32'(in_txn), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit: the initiator that drives the byte-addressed data memory on behalf of the RV32I core.
- Accepts one load or store request at a time and issues word-aligned accesses to the memory port.
- Extracts and sign- or zero-extends sub-word load data.
- Performs read-modify-write for SB/SH, because the memory writes only whole 32-bit words.

Parameters:
- AW, 10, memory byte-address width; matches the memory addr port.
- DEPTH, 1024, memory size in bytes; must equal 2**AW.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- req_addr  in  32  byte address from the core.
- req_wdata  in  32  store data; low bytes used for SB/SH.
- resp_valid  out  1  one-cycle pulse marking completion.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid; request rejected.
- mem_addr  out  AW  word-aligned byte address to memory.
- mem_rW  out  1  1 = write, 0 = read.
- mem_en  out  1  memory enable.
- mem_dataIn  out  32  write data to memory.
- mem_dataOut  in  32  memory read data; registered by memory, valid the cycle after a read is issued.

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0 except req_ready=1.
- States: IDLE, READ, CAPT, WRITE, RESP. All outputs are registered.
- IDLE: req_ready=1. Accept on req_valid && req_ready at posedge E0.
- Checks at accept, giving err=1:
  - req_addr[31:AW] != 0.
  - Halfword access with addr[0] != 0.
  - Word access with addr[1:0] != 0.
  - Illegal funct3: loads allow 000, 001, 010, 100, 101; stores allow 000, 001, 010 only.
- Error path: IDLE -> RESP with resp_err=1 and resp_rdata=0. mem_en stays 0 for the whole transaction.
- Latched at accept: base = {addr[AW-1:2], 2'b00}, the lane addr[1:0], funct3, we and wdata. The unit ignores request inputs after acceptance.
- Load: IDLE -> READ -> CAPT -> RESP -> IDLE.
  - READ: mem_en=1, mem_rW=0, mem_addr=base.
  - CAPT: mem_en=0; mem_dataOut is valid. Lane extract:
    - LB/LBU: byte = word[8*lane +: 8].
    - LH/LHU: half = word[16*lane[1] +: 16].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Result registered into resp_rdata at the CAPT->RESP edge. resp_valid asserts 3 cycles after accept.
- SW: IDLE -> WRITE -> RESP.
  - WRITE: mem_en=1, mem_rW=1, mem_addr=base, mem_dataIn=wdata.
  - resp_valid asserts 2 cycles after accept.
- SB/SH: IDLE -> READ -> CAPT -> WRITE -> RESP.
  - mem_dataIn = the read word with only the addressed byte or half replaced by wdata[7:0] or wdata[15:0].
  - resp_valid asserts 4 cycles after accept.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata and resp_err hold until the next RESP.
  - req_ready=0 in RESP, so back-to-back requests are spaced by at least one IDLE cycle.
- mem_en is high only in READ and WRITE. mem_addr and mem_dataIn hold their last values otherwise.
- Highest legal word base is DEPTH-4, so the memory never indexes beyond DEPTH-1.
- Reset mid-transaction: abort immediately and drop mem_en. No resp_valid is produced. A WRITE cycle cut by reset may or may not have committed.
- The memory's own synchronous rst is driven elsewhere, not by this block.

Decomposition:
- Shared package dmem_lsu_pkg holds:
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - The state encoding.
  - AW and DEPTH defaults.
- One combinational sub-module, lsu_byte_lane:
  - Inputs: word, lane, funct3, wdata.
  - Outputs: extended load data and merged store word.
- The FSM, checks and registers stay in dmem_lsu.

Test Plan:
- Preload word 0x804020F1 at base 0x10. Then:
  - LB 0x10 -> resp_rdata 0xFFFFFFF1, resp_valid exactly 3 cycles after accept.
  - LBU 0x13 -> 0x00000080.
  - LH 0x12 -> 0xFFFF8040.
  - LHU 0x12 -> 0x00008040.
  - LW 0x10 -> 0x804020F1.
- SB 0x11 with wdata 0x123456AB -> one READ then one WRITE of 0x8040ABF1 at mem_addr 0x10. Then LW 0x10 -> 0x8040ABF1.
  - SH 0x12 with wdata 0xBEEF -> word 0xBEEFABF1.
- SW 0x3FC with 0xDEADBEEF -> a single WRITE cycle, resp_valid 2 cycles after accept. Then LW 0x3FC -> 0xDEADBEEF.
- Each of these produces resp_err=1 and resp_rdata=0 in the cycle after accept, with mem_en never asserted:
  - LW 0x12.
  - LH 0x13.
  - LW 0x400.
  - Store with funct3=100.
- Assert rst low during CAPT of an SB -> all outputs 0 at once, no WRITE and no resp_valid. After release, req_ready=1 and a fresh LW returns the unmodified word.
- Hold req_valid high with back-to-back LW requests -> req_ready low from accept through RESP, each response returned in order, with no memory activity overlapping between transactions.
